// File: rtl/pipe_mul_unit.sv
// Fully pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU) with per-stage valid/ready.
// Optional MUL_FLUSH_EN adds a flush port that squashes every in-flight op.
module pipe_mul_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 48
) (
  input  logic             clock,
  input  logic             reset,
`ifdef MUL_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_func,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned W = 2 * XLEN;
  localparam int unsigned C = W / STAGES;

  logic              flush_w;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ready;
  logic              full;
  logic [W-1:0]      opa_ext, opb_ext;

  logic [W-1:0]      acc_q    [STAGES];
  logic [W-1:0]      mplier_q [STAGES];
  logic [W-1:0]      mcand_q  [STAGES];
  logic [1:0]        func_q   [STAGES];
  logic [TAG_W-1:0]  tag_q    [STAGES];

  logic [W-1:0]      acc_d    [STAGES];
  logic [W-1:0]      mplier_d [STAGES];
  logic [W-1:0]      mcand_d  [STAGES];
  logic              s_valid  [STAGES];
  logic [W-1:0]      s_acc    [STAGES];
  logic [W-1:0]      s_mplier [STAGES];
  logic [W-1:0]      s_mcand  [STAGES];
  logic [1:0]        s_func   [STAGES];
  logic [TAG_W-1:0]  s_tag    [STAGES];

`ifdef MUL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign opa_ext = (in_func != 2'b11) ? {{XLEN{in_opa[XLEN-1]}}, in_opa} : {{XLEN{1'b0}}, in_opa};
  assign opb_ext = !in_func[1] ? {{XLEN{in_opb[XLEN-1]}}, in_opb} : {{XLEN{1'b0}}, in_opb};

  // Stage i can take new data unless it and every stage after it is full and the CDB stalls.
  always_comb begin
    ready = '0;
    full  = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full     = full & valid_q[i];
      ready[i] = out_ready || !full;
    end
  end

  assign in_ready = ready[0] && !flush_w;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign s_valid[i]  = in_valid;
      assign s_acc[i]    = '0;
      assign s_mplier[i] = opb_ext;
      assign s_mcand[i]  = opa_ext;
      assign s_func[i]   = in_func;
      assign s_tag[i]    = in_tag;
    end else begin : g_next
      assign s_valid[i]  = valid_q[i-1];
      assign s_acc[i]    = acc_q[i-1];
      assign s_mplier[i] = mplier_q[i-1];
      assign s_mcand[i]  = mcand_q[i-1];
      assign s_func[i]   = func_q[i-1];
      assign s_tag[i]    = tag_q[i-1];
    end
    // Modular chunk products sum to the exact two's-complement product of the extended operands.
    assign acc_d[i]    = s_acc[i] + W'(s_mplier[i][C-1:0]) * s_mcand[i];
    assign mplier_d[i] = s_mplier[i] >> C;
    assign mcand_d[i]  = s_mcand[i] << C;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush_w) begin
          valid_q[i] <= 1'b0;
        end else if (ready[i]) begin
          valid_q[i] <= s_valid[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < STAGES; i++) begin
      if (ready[i] && s_valid[i] && !flush_w) begin
        acc_q[i]    <= acc_d[i];
        mplier_q[i] <= mplier_d[i];
        mcand_q[i]  <= mcand_d[i];
        func_q[i]   <= s_func[i];
        tag_q[i]    <= s_tag[i];
      end
    end
  end

  // Data registers are not reset, so outputs are masked while no result is held.
  always_comb begin
    out_valid  = valid_q[STAGES-1];
    out_result = '0;
    out_tag    = '0;
    if (valid_q[STAGES-1]) begin
      out_tag    = tag_q[STAGES-1];
      out_result = (func_q[STAGES-1] == 2'b00) ? acc_q[STAGES-1][XLEN-1:0]
                                               : acc_q[STAGES-1][W-1:XLEN];
    end
  end

endmodule
